// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer
//   Buffers one frame of per-bin bar magnitudes into a back bank. At the next
//   vertical-blank rising edge it commits that frame into the registered
//   display array, applying a saturating per-bin fall-off so bars decay
//   smoothly. The display array only changes at frame boundaries.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : input beat valid
//   in_ready     : block accepts a beat (FILL/DRAIN only, low during reset)
//   in_data      : magnitude for the next bin, bins streamed from 0 upward
//   in_last      : final beat of a frame
//   vblank       : vertical-blank level; rising edge marks the frame boundary
//   value        : registered display magnitudes, bins 0..SAMPLES
//   stale_frame  : one-cycle pulse, frame boundary seen before a full frame
//   frame_error  : one-cycle pulse, frame ran past SAMPLES+1 beats
module spectrum_frame_buffer #(
  parameter int                SAMPLES = 32,
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  DECAY   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             vblank,
  output logic [WIDTH-1:0] value [0:SAMPLES],
  output logic             stale_frame,
  output logic             frame_error
);

  localparam int               IDX_W    = $clog2(SAMPLES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES);
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(SAMPLES + 1);

  typedef enum logic [1:0] {FILL, DRAIN, HOLD, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0] back_q [0:SAMPLES];
  logic [WIDTH-1:0] back_d [0:SAMPLES];
  logic [WIDTH-1:0] value_q [0:SAMPLES];
  logic [WIDTH-1:0] value_d [0:SAMPLES];
  logic             stale_q, stale_d;
  logic             ferr_q, ferr_d;
  logic             vblank_s_q, vblank_s_d;
  logic             vblank_d_q, vblank_d_d;

  logic             accept;
  logic             complete;
  logic             vb_edge;

  // Decay that clamps at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] decay_sat(input logic [WIDTH-1:0] v);
    return (v >= DECAY) ? v - DECAY : '0;
  endfunction

  function automatic logic [WIDTH-1:0] max_mag(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  assign in_ready    = rst_n && ((state_q == FILL) || (state_q == DRAIN));
  assign accept      = in_valid && in_ready;
  assign complete    = accept && in_last;
  // vblank is sampled once before edge detection, so the boundary is seen
  // the cycle after vblank is first registered high.
  assign vb_edge     = vblank_s_q && !vblank_d_q;
  assign value       = value_q;
  assign stale_frame = stale_q;
  assign frame_error = ferr_q;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    fill_cnt_d = fill_cnt_q;
    back_d     = back_q;
    value_d    = value_q;
    stale_d    = 1'b0;
    ferr_d     = 1'b0;
    vblank_s_d = vblank;
    vblank_d_d = vblank_s_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          back_d[wr_idx_q] = in_data;
          wr_idx_d         = wr_idx_q + IDX_W'(1);
          if (in_last) begin
            fill_cnt_d = wr_idx_q + IDX_W'(1);
            state_d    = vb_edge ? COMMIT : HOLD;
          end else if (wr_idx_q == LAST_IDX) begin
            fill_cnt_d = FULL_CNT;
            ferr_d     = 1'b1;
            state_d    = DRAIN;
          end
        end
        if (vb_edge && !complete) stale_d = 1'b1;
      end
      DRAIN: begin
        if (complete) state_d = vb_edge ? COMMIT : HOLD;
        if (vb_edge && !complete) stale_d = 1'b1;
      end
      HOLD: begin
        if (vb_edge) state_d = COMMIT;
      end
      COMMIT: begin
        // Bins past the end of a short frame take 0 as the new sample.
        for (int i = 0; i <= SAMPLES; i++) begin
          value_d[i] = max_mag((IDX_W'(i) < fill_cnt_q) ? back_q[i] : '0,
                               decay_sat(value_q[i]));
        end
        wr_idx_d   = '0;
        fill_cnt_d = '0;
        state_d    = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wr_idx_q   <= '0;
      fill_cnt_q <= '0;
      stale_q    <= 1'b0;
      ferr_q     <= 1'b0;
      vblank_s_q <= 1'b1;
      vblank_d_q <= 1'b1;
      for (int i = 0; i <= SAMPLES; i++) begin
        back_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      fill_cnt_q <= fill_cnt_d;
      stale_q    <= stale_d;
      ferr_q     <= ferr_d;
      vblank_s_q <= vblank_s_d;
      vblank_d_q <= vblank_d_d;
      back_q     <= back_d;
      value_q    <= value_d;
    end
  end

endmodule
